// File: rtl/rr_mux_arbiter.sv
// Round-robin arbitrated N:1 val/rdy mux with packet locking.
// A requester that wins arbitration keeps the output until its beat flagged
// last has fired, so multi-beat packets are never interleaved.
module rr_mux_arbiter #(
  parameter int p_nbits = 32,
  parameter int p_nreqs = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nreqs-1:0]                in_val,
  output logic [p_nreqs-1:0]                in_rdy,
  input  logic [p_nreqs-1:0]                in_last,
  input  logic [p_nreqs-1:0][p_nbits-1:0]   in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_nbits-1:0]                out_msg,
  output logic                              out_last,
  output logic [$clog2(p_nreqs)-1:0]        grant_idx,
  output logic                              locked
);

  localparam int p_iw = $clog2(p_nreqs);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [p_iw-1:0]   ptr;
  logic [p_iw-1:0]   lidx;
  logic [p_iw-1:0]   arb_grant;
  logic [p_iw-1:0]   grant;
  logic              any_val;
  logic              fire;

  // Index arithmetic modulo p_nreqs; keeps ptr/lidx in range for any p_nreqs.
  function automatic logic [p_iw-1:0] wrap_add(input logic [p_iw-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(p_nreqs)) s = s - 32'(p_nreqs);
    return s[p_iw-1:0];
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    arb_grant = ptr;
    for (int k = p_nreqs - 1; k >= 0; k--) begin
      if (in_val[wrap_add(ptr, k)]) arb_grant = wrap_add(ptr, k);
    end
  end

  assign any_val = |in_val;
  assign grant   = (state == LOCKED) ? lidx : arb_grant;

  // Mux datapath and handshake; everything is forced quiet while reset is high.
  always_comb begin
    in_rdy    = '0;
    out_val   = 1'b0;
    out_msg   = '0;
    out_last  = 1'b0;
    grant_idx = '0;
    locked    = 1'b0;
    if (!reset) begin
      out_val   = (state == LOCKED) ? in_val[lidx] : any_val;
      out_msg   = in_msg[grant];
      out_last  = in_last[grant];
      grant_idx = grant;
      locked    = (state == LOCKED);
      // An idle arbiter with no requests offers ready to nobody.
      if (state == LOCKED || any_val) in_rdy[grant] = out_rdy;
    end
  end

  assign fire = out_val & out_rdy;

  // State, pointer and lock index advance only when a beat fires.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      lidx  <= '0;
    end else if (fire) begin
      if (out_last) begin
        state <= IDLE;
        ptr   <= wrap_add(grant, 1);
      end else if (state == IDLE) begin
        state <= LOCKED;
        lidx  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed-vector bench for rr_mux_arbiter (4 requesters, 32-bit messages).
module tb_rr_mux_arbiter;

  localparam int p_nbits = 32;
  localparam int p_nreqs = 4;

  logic                            clk = 1'b0;
  logic                            reset;
  logic [p_nreqs-1:0]              in_val;
  logic [p_nreqs-1:0]              in_rdy;
  logic [p_nreqs-1:0]              in_last;
  logic [p_nreqs-1:0][p_nbits-1:0] in_msg;
  logic                            out_val;
  logic                            out_rdy;
  logic [p_nbits-1:0]              out_msg;
  logic                            out_last;
  logic [1:0]                      grant_idx;
  logic                            locked;

  int n_vec = 0;
  int n_bad = 0;

  rr_mux_arbiter #(.p_nbits(p_nbits), .p_nreqs(p_nreqs)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_last   (in_last),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .out_last  (out_last),
    .grant_idx (grant_idx),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then leave 1ns so new inputs are applied clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 4'b1111;
    in_last = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < p_nreqs; i++) in_msg[i] = 32'hA0 + 32'(i);

    // 1. Outputs quiet during reset even with requests pending, idle afterwards.
    #2;
    check("rst_out_val", 32'(out_val), 0);
    check("rst_in_rdy", 32'(in_rdy), 0);
    tick();
    tick();
    reset  = 1'b0;
    in_val = 4'b0000;
    #1;
    check("idle_out_val", 32'(out_val), 0);
    check("idle_in_rdy", 32'(in_rdy), 0);
    check("idle_grant", 32'(grant_idx), 0);
    check("idle_locked", 32'(locked), 0);

    // 2. All requesting single-beat packets: strict rotation A0..A3 twice.
    in_val = 4'b1111;
    #1;
    for (int b = 0; b < 8; b++) begin
      check($sformatf("rot_val_%0d", b), 32'(out_val), 1);
      check($sformatf("rot_msg_%0d", b), out_msg, 32'hA0 + 32'(b % 4));
      check($sformatf("rot_rdy_%0d", b), 32'(in_rdy), 32'(1) << (b % 4));
      tick();
    end

    // 3. Backpressure holds the offer and the pointer; release fires A0.
    out_rdy = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_val_%0d", c), 32'(out_val), 1);
      check($sformatf("bp_msg_%0d", c), out_msg, 32'hA0);
      check($sformatf("bp_rdy_%0d", c), 32'(in_rdy), 0);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    check("bp_rel_msg", out_msg, 32'hA0);
    check("bp_rel_rdy", 32'(in_rdy), 32'h1);
    tick();
    check("bp_next_grant", 32'(grant_idx), 1);
    in_val = 4'b0000;
    #1;
    check("bp_ptr", 32'(grant_idx), 1);

    // 4. Req 1 sends a 3-beat packet with a bubble while req 2 waits.
    in_val  = 4'b0110;
    in_last = 4'b0100;
    #1;
    check("pkt_b1_grant", 32'(grant_idx), 1);
    check("pkt_b1_locked", 32'(locked), 0);
    check("pkt_b1_msg", out_msg, 32'hA1);
    tick();
    check("pkt_b2_locked", 32'(locked), 1);
    check("pkt_b2_grant", 32'(grant_idx), 1);
    check("pkt_b2_rdy", 32'(in_rdy), 32'h2);
    tick();
    in_val = 4'b0100;
    #1;
    check("pkt_bub_val", 32'(out_val), 0);
    check("pkt_bub_grant", 32'(grant_idx), 1);
    check("pkt_bub_rdy2", 32'(in_rdy[2]), 0);
    check("pkt_bub_locked", 32'(locked), 1);
    tick();
    in_val  = 4'b0110;
    in_last = 4'b0110;
    #1;
    check("pkt_b3_last", 32'(out_last), 1);
    check("pkt_b3_msg", out_msg, 32'hA1);
    tick();
    check("pkt_end_grant", 32'(grant_idx), 2);
    check("pkt_end_locked", 32'(locked), 0);

    // 5. Drain req 2, then req 3 alone wraps the pointer to 0.
    in_val  = 4'b0100;
    in_last = 4'b1111;
    tick();
    in_val = 4'b1000;
    #1;
    check("wrap_grant3", 32'(grant_idx), 3);
    check("wrap_msg3", out_msg, 32'hA3);
    tick();
    in_val = 4'b0000;
    #1;
    check("wrap_ptr", 32'(grant_idx), 0);
    out_rdy = 1'b0;
    in_val  = 4'b1001;
    #1;
    check("wrap_grant0", 32'(grant_idx), 0);
    check("wrap_msg0", out_msg, 32'hA0);

    // 6. Reset in the middle of a 4-beat packet from req 2.
    out_rdy = 1'b1;
    in_val  = 4'b0100;
    in_last = 4'b0000;
    #1;
    check("mid_b1_grant", 32'(grant_idx), 2);
    tick();
    check("mid_b2_locked", 32'(locked), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_val", 32'(out_val), 0);
    check("mid_rst_rdy", 32'(in_rdy), 0);
    check("mid_rst_locked", 32'(locked), 0);
    tick();
    reset  = 1'b0;
    in_val = 4'b0000;
    #1;
    check("mid_post_locked", 32'(locked), 0);
    check("mid_post_ptr", 32'(grant_idx), 0);
    in_val = 4'b0101;
    #1;
    check("mid_post_grant", 32'(grant_idx), 0);
    check("mid_post_msg", out_msg, 32'hA0);
    check("mid_post_rdy", 32'(in_rdy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
